// File: rtl/debug_pkg.sv
// Shared constants, frame layout and state encoding for the debugger dump link.
package debug_pkg;

  localparam int FRAME_BYTES = 324;
  localparam int FRAME_W     = FRAME_BYTES * 8;
  localparam int IDX_W       = $clog2(FRAME_BYTES);

  // Frame layout: {2'b0, clk_count[31:0], pipe_data[2557:0]}
  localparam int PIPE_W      = 2558;
  localparam int CLKCNT_W    = 32;
  localparam int PIPE_LSB    = 0;
  localparam int CLKCNT_LSB  = 2558;
  localparam int FCOUNT_W    = 16;

  // Command bytes sent by the host to the debugger send FSM.
  localparam logic [7:0] LOAD = 8'h01;
  localparam logic [7:0] FAST = 8'h02;
  localparam logic [7:0] STEP = 8'h03;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    RECV  = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_e;

endpackage

// File: rtl/debug_frame_rx_if.sv
// Byte-stream input and frame-result bundle of the dump-link receiver.
interface debug_frame_rx_if;
  import debug_pkg::*;

  // Strobe semantics, no back-pressure: is_rx_done and is_start are single-cycle
  // strobes that the receiver samples every cycle; a byte is taken exactly in the
  // cycle is_rx_done=1 (with i_rx_data) and is never held or re-presented.
  // os_done/os_timeout are single-cycle result pulses.
  logic [7:0]          i_rx_data;
  logic                is_rx_done;
  logic                is_start;
  logic [PIPE_W-1:0]   o_pipe_data;
  logic [CLKCNT_W-1:0] o_clk_count;
  logic [FCOUNT_W-1:0] o_frame_count;
  logic                os_busy;
  logic                os_done;
  logic                os_timeout;
  state_e              dbg_state;

  modport master (
    output i_rx_data, is_rx_done, is_start,
    input  o_pipe_data, o_clk_count, o_frame_count,
    input  os_busy, os_done, os_timeout, dbg_state
  );

  modport slave (
    input  i_rx_data, is_rx_done, is_start,
    output o_pipe_data, o_clk_count, o_frame_count,
    output os_busy, os_done, os_timeout, dbg_state
  );

endinterface

// File: rtl/debug_byte_deser.sv
// Byte index counter and byte-lane writer into the frame shadow buffer.
module debug_byte_deser
  import debug_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               wr_en,
  input  logic [7:0]         wr_data,
  output logic               last,
  output logic [FRAME_W-1:0] shadow
);

  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [FRAME_W-1:0] shadow_q, shadow_d;

  always_comb begin
    idx_d    = idx_q;
    shadow_d = shadow_q;
    // Byte k lands on bits [8k+7:8k]; idx*8 is formed by appending three zeros.
    if (wr_en) begin
      shadow_d[{idx_q, 3'b000} +: 8] = wr_data;
      idx_d = idx_q + IDX_W'(1);
    end
    if (clr) begin
      idx_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_q    <= '0;
      shadow_q <= '0;
    end else begin
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
    end
  end

  assign last   = (idx_q == IDX_W'(FRAME_BYTES - 1));
  assign shadow = shadow_q;

endmodule

// File: rtl/debug_frame_rx.sv
// Dump-link receiver: arms on is_start, assembles one frame of bytes,
// publishes pipe/clock-count fields on completion, drops stalled frames.
module debug_frame_rx
  import debug_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic             clk,
  input logic             rst,
  debug_frame_rx_if.slave bus
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PIPE_W-1:0]   pipe_q, pipe_d;
  logic [CLKCNT_W-1:0] clkcnt_q, clkcnt_d;
  logic [FCOUNT_W-1:0] frames_q, frames_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                tmo_q, tmo_d;

  logic                wr_en;
  logic                idx_clr;
  logic                last_byte;
  logic [FRAME_W-1:0]  shadow;
  logic                unused_top_bits;

  debug_byte_deser u_deser (
    .clk     (clk),
    .rst     (rst),
    .clr     (idx_clr),
    .wr_en   (wr_en),
    .wr_data (bus.i_rx_data),
    .last    (last_byte),
    .shadow  (shadow)
  );

  // The two top frame bits carry no information and are deliberately dropped.
  assign unused_top_bits = ^shadow[FRAME_W-1:CLKCNT_LSB+CLKCNT_W];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pipe_d   = pipe_q;
    clkcnt_d = clkcnt_q;
    frames_d = frames_q;
    done_d   = 1'b0;
    tmo_d    = 1'b0;
    wr_en    = 1'b0;
    idx_clr  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.is_start) state_d = ARMED;
      end
      ARMED: begin
        cnt_d = '0;
        if (bus.is_rx_done) begin
          wr_en   = 1'b1;
          state_d = last_byte ? DONE : RECV;
        end
      end
      RECV: begin
        // A byte arriving on the expiry cycle still counts and restarts the gap timer.
        if (bus.is_rx_done) begin
          wr_en = 1'b1;
          cnt_d = '0;
          if (last_byte) state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_LAST) state_d = ERR;
        end
      end
      DONE: begin
        pipe_d   = shadow[PIPE_LSB +: PIPE_W];
        clkcnt_d = shadow[CLKCNT_LSB +: CLKCNT_W];
        frames_d = frames_q + FCOUNT_W'(1);
        done_d   = 1'b1;
        idx_clr  = 1'b1;
        cnt_d    = '0;
        state_d  = IDLE;
      end
      ERR: begin
        tmo_d   = 1'b1;
        idx_clr = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        idx_clr = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pipe_q   <= '0;
      clkcnt_q <= '0;
      frames_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pipe_q   <= pipe_d;
      clkcnt_q <= clkcnt_d;
      frames_q <= frames_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      tmo_q    <= tmo_d;
    end
  end

  assign bus.o_pipe_data   = pipe_q;
  assign bus.o_clk_count   = clkcnt_q;
  assign bus.o_frame_count = frames_q;
  assign bus.os_busy       = busy_q;
  assign bus.os_done       = done_q;
  assign bus.os_timeout    = tmo_q;
  assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_debug_frame_rx.sv
// Directed bench for debug_frame_rx: table of full frames plus hand-written
// timeout, stray-byte, mid-frame reset and exact-expiry sequences.
module tb_debug_frame_rx;
  import debug_pkg::*;

  localparam int TMO = 16;

  typedef struct {
    string       name;
    bit          ramp;
    int          gap;
    logic [7:0]  fill;
    logic [1:0]  top;
    logic [31:0] clk;
    logic [31:0] exp_clk;
  } vec_t;

  logic clk;
  logic rst;

  debug_frame_rx_if bus ();

  debug_frame_rx #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  int                  n_checks = 0;
  int                  n_pass   = 0;
  int                  done_seen = 0;
  int                  tmo_seen  = 0;
  int                  exp_done_total = 0;
  logic [31:0]         exp_q[$];
  logic [FCOUNT_W-1:0] exp_frames;
  logic [PIPE_W-1:0]   exp_pipe;
  logic [31:0]         exp_clk_last;

  always @(negedge clk) begin
    if (bus.os_done === 1'b1) done_seen++;
    if (bus.os_timeout === 1'b1) tmo_seen++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic chk_wide(input string name, input logic [PIPE_W-1:0] act,
                          input logic [PIPE_W-1:0] exp);
    int first;
    n_checks++;
    if (act !== exp) begin
      first = -1;
      for (int i = PIPE_W - 1; i >= 0; i--) if (act[i] !== exp[i]) first = i;
      $display("FAIL %s: first differing bit %0d got %b expected %b",
               name, first, act[first], exp[first]);
    end else begin
      n_pass++;
    end
  endtask

  // Driver tasks: each is entered on a negedge and returns on a negedge.
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_data  = b;
    bus.is_rx_done = 1'b1;
    @(negedge clk);
    bus.is_rx_done = 1'b0;
  endtask

  task automatic send_bytes(input logic [FRAME_W-1:0] f, input int from, input int to,
                            input int gap);
    for (int k = from; k <= to; k++) begin
      send_byte(f[8*k +: 8]);
      if (k != to) idle(gap);
    end
  endtask

  task automatic strobe_start();
    bus.is_start = 1'b1;
    @(negedge clk);
    bus.is_start = 1'b0;
  endtask

  function automatic logic [FRAME_W-1:0] make_frame(input vec_t v);
    logic [FRAME_W-1:0] f;
    for (int k = 0; k < FRAME_BYTES; k++) f[8*k +: 8] = v.ramp ? 8'(k) : v.fill;
    if (!v.ramp) begin
      f[CLKCNT_LSB +: CLKCNT_W] = v.clk;
      f[FRAME_W-1 -: 2]         = v.top;
    end
    return f;
  endfunction

  // Called on the negedge right after the clock that captured the last byte.
  task automatic check_done(input string tag, input bit start_on_done);
    logic [31:0] e_clk;
    chk({tag, "_done_early"}, 64'(bus.os_done), 64'(0));
    chk({tag, "_busy_in_done"}, 64'(bus.os_busy), 64'(1));
    if (start_on_done) bus.is_start = 1'b1;
    idle(1);
    bus.is_start = 1'b0;
    exp_frames = exp_frames + 16'd1;
    exp_done_total++;
    e_clk = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
    exp_clk_last = e_clk;
    chk({tag, "_done_pulse"}, 64'(bus.os_done), 64'(1));
    chk({tag, "_busy_after"}, 64'(bus.os_busy), 64'(0));
    chk({tag, "_clk_count"}, 64'(bus.o_clk_count), 64'(e_clk));
    chk_wide({tag, "_pipe_data"}, bus.o_pipe_data, exp_pipe);
    chk({tag, "_frame_count"}, 64'(bus.o_frame_count), 64'(exp_frames));
    idle(1);
    chk({tag, "_done_single"}, 64'(bus.os_done), 64'(0));
    chk({tag, "_idle_after"}, 64'(bus.dbg_state), 64'(IDLE));
  endtask

  task automatic run_frame(input string tag, input logic [FRAME_W-1:0] f,
                           input logic [31:0] e_clk, input int gap);
    strobe_start();
    chk({tag, "_armed"}, 64'(bus.dbg_state), 64'(ARMED));
    exp_q.push_back(e_clk);
    exp_pipe = f[PIPE_W-1:0];
    send_bytes(f, 0, FRAME_BYTES - 1, gap);
    check_done(tag, 1'b0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pipe"}, 64'(bus.o_pipe_data[63:0]), 64'(0));
    chk_wide({tag, "_pipe_all"}, bus.o_pipe_data, '0);
    chk({tag, "_clk"}, 64'(bus.o_clk_count), 64'(0));
    chk({tag, "_frames"}, 64'(bus.o_frame_count), 64'(0));
    chk({tag, "_busy"}, 64'(bus.os_busy), 64'(0));
    chk({tag, "_done"}, 64'(bus.os_done), 64'(0));
    chk({tag, "_timeout"}, 64'(bus.os_timeout), 64'(0));
    chk({tag, "_state"}, 64'(bus.dbg_state), 64'(IDLE));
  endtask

  vec_t               tbl[4];
  vec_t               v;
  logic [FRAME_W-1:0] f;

  initial begin
    tbl[0] = '{"ramp",    1'b1, 3,  8'h00, 2'b00, 32'h0,        32'h0D090500};
    tbl[1] = '{"ones",    1'b0, 0,  8'hFF, 2'b00, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[2] = '{"zeros",   1'b0, 14, 8'h00, 2'b11, 32'h12345678, 32'h12345678};
    tbl[3] = '{"pattern", 1'b0, 1,  8'hA5, 2'b10, 32'h80000001, 32'h80000001};

    rst            = 1'b0;
    bus.i_rx_data  = 8'h00;
    bus.is_rx_done = 1'b0;
    bus.is_start   = 1'b0;
    exp_frames     = '0;
    exp_pipe       = '0;
    exp_clk_last   = '0;
    idle(3);
    chk_reset_state("reset");
    rst = 1'b1;
    idle(1);

    // Stray bytes with no is_start are discarded
    for (int i = 0; i < 5; i++) send_byte(8'hEE);
    chk("stray_busy", 64'(bus.os_busy), 64'(0));
    chk("stray_state", 64'(bus.dbg_state), 64'(IDLE));
    idle(2);

    // Table of full frames
    for (int t = 0; t < 4; t++) begin
      v = tbl[t];
      f = make_frame(v);
      run_frame(v.name, f, v.exp_clk, v.gap);
      if (v.ramp) begin
        chk("ramp_pipe_byte0", 64'(bus.o_pipe_data[7:0]), 64'(8'h00));
        chk("ramp_pipe_byte1", 64'(bus.o_pipe_data[15:8]), 64'(8'h01));
        chk("ramp_pipe_top", 64'(bus.o_pipe_data[PIPE_W-1 -: 6]), 64'(6'h3F));
      end
      if (v.fill == 8'hFF) begin
        chk_wide("ones_all_set", bus.o_pipe_data, {PIPE_W{1'b1}});
      end
      idle(2);
    end

    // Inter-byte timeout: 10 bytes then a stall
    f = make_frame('{"tmo", 1'b0, 0, 8'h5A, 2'b00, 32'h11112222, 32'h0});
    strobe_start();
    send_bytes(f, 0, 9, 0);
    idle(TMO - 1);
    chk("tmo_not_early", 64'(bus.os_timeout), 64'(0));
    chk("tmo_busy_before", 64'(bus.os_busy), 64'(1));
    idle(1);
    chk("tmo_pulse", 64'(bus.os_timeout), 64'(1));
    chk("tmo_busy_after", 64'(bus.os_busy), 64'(0));
    chk("tmo_frames_kept", 64'(bus.o_frame_count), 64'(exp_frames));
    chk("tmo_clk_kept", 64'(bus.o_clk_count), 64'(exp_clk_last));
    chk_wide("tmo_pipe_kept", bus.o_pipe_data, exp_pipe);
    idle(1);
    chk("tmo_single", 64'(bus.os_timeout), 64'(0));
    idle(3);
    f = make_frame('{"after_tmo", 1'b0, 0, 8'hC3, 2'b01, 32'hCAFEF00D, 32'h0});
    run_frame("after_tmo", f, 32'hCAFEF00D, 0);
    idle(2);

    // Reset pulled mid-frame after byte 200
    f = make_frame('{"rst_mid", 1'b0, 0, 8'h3C, 2'b00, 32'h55AA55AA, 32'h0});
    strobe_start();
    send_bytes(f, 0, 199, 0);
    rst = 1'b0;
    idle(1);
    chk_reset_state("mid_reset");
    rst = 1'b1;
    exp_frames = '0;
    idle(1);
    f = make_frame('{"post_rst", 1'b0, 0, 8'h96, 2'b00, 32'h0BADC0DE, 32'h0});
    run_frame("post_rst", f, 32'h0BADC0DE, 0);
    chk("post_rst_frames_one", 64'(bus.o_frame_count), 64'(1));
    idle(2);

    // Second is_start mid-frame, byte on the exact expiry cycle, is_start during DONE
    f = make_frame('{"restart", 1'b0, 0, 8'h0F, 2'b00, 32'hFEDCBA98, 32'h0});
    strobe_start();
    exp_q.push_back(32'hFEDCBA98);
    exp_pipe = f[PIPE_W-1:0];
    send_bytes(f, 0, 100, 0);
    bus.is_start = 1'b1;
    idle(1);
    bus.is_start = 1'b0;
    chk("restart_ignored", 64'(bus.dbg_state), 64'(RECV));
    idle(TMO - 3);
    send_bytes(f, 101, 101, 0);
    chk("edge_byte_no_tmo", 64'(bus.os_timeout), 64'(0));
    chk("edge_byte_state", 64'(bus.dbg_state), 64'(RECV));
    idle(1);
    chk("edge_byte_no_tmo_late", 64'(bus.os_timeout), 64'(0));
    send_bytes(f, 102, FRAME_BYTES - 1, 0);
    check_done("restart", 1'b1);
    idle(3);

    chk("total_done_pulses", 64'(done_seen), 64'(exp_done_total));
    chk("total_timeout_pulses", 64'(tmo_seen), 64'(1));
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
